// File: rtl/led_fade_sequencer.sv
// Triangular LED fade: PWM ramp up, hold, ramp down, hold.
// Define LED_FADE_REPEAT_EN to loop the fade until stop or reset.
module led_fade_sequencer #(
  parameter int LENGTH     = 30,
  parameter int SPEED_DOWN = 300,
  parameter int HOLD       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  output logic       led,
  output logic       busy,
  output logic [7:0] duty,
  output logic       cycle_done
);

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    HOLD_ON,
    RAMP_DOWN,
    HOLD_OFF
  } state_t;

  localparam logic [7:0]  DUTY_MAX  = 8'(LENGTH);
  localparam logic [7:0]  PWM_LAST  = 8'(LENGTH - 1);
  localparam logic [15:0] STEP_LAST = 16'(SPEED_DOWN - 1);
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD - 1);

  state_t      state_q;
  logic [7:0]  pwm_q;
  logic [7:0]  pwm_d;
  logic [7:0]  duty_q;
  logic [7:0]  hold_q;
  logic [15:0] step_q;
  logic [15:0] step_d;
  logic        tick;
  logic        led_q;
  logic        done_q;

  assign tick   = (step_q == STEP_LAST);
  assign step_d = tick ? '0 : step_q + 16'd1;
  assign pwm_d  = (pwm_q == PWM_LAST) ? '0 : pwm_q + 8'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pwm_q   <= '0;
      duty_q  <= '0;
      hold_q  <= '0;
      step_q  <= '0;
      led_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop) begin
        state_q <= IDLE;
        pwm_q   <= '0;
        duty_q  <= '0;
        hold_q  <= '0;
        step_q  <= '0;
        led_q   <= 1'b0;
      end else begin
        led_q  <= (state_q != IDLE) && (pwm_q < duty_q);
        pwm_q  <= (state_q == IDLE) ? '0 : pwm_d;
        step_q <= (state_q == IDLE) ? '0 : step_d;
        // every transition below happens on a tick, so step_d is already 0
        unique case (state_q)
          IDLE: begin
            hold_q <= '0;
            duty_q <= '0;
            if (start) begin
              state_q <= RAMP_UP;
            end
          end
          RAMP_UP: begin
            if (tick) begin
              if (duty_q >= PWM_LAST) begin
                duty_q  <= DUTY_MAX;
                hold_q  <= '0;
                state_q <= HOLD_ON;
              end else begin
                duty_q <= duty_q + 8'd1;
              end
            end
          end
          HOLD_ON: begin
            if (tick) begin
              if (hold_q == HOLD_LAST) begin
                hold_q  <= '0;
                state_q <= RAMP_DOWN;
              end else begin
                hold_q <= hold_q + 8'd1;
              end
            end
          end
          RAMP_DOWN: begin
            if (tick) begin
              if (duty_q <= 8'd1) begin
                duty_q  <= '0;
                hold_q  <= '0;
                state_q <= HOLD_OFF;
              end else begin
                duty_q <= duty_q - 8'd1;
              end
            end
          end
          HOLD_OFF: begin
            if (tick) begin
              if (hold_q == HOLD_LAST) begin
                hold_q <= '0;
                done_q <= 1'b1;
`ifdef LED_FADE_REPEAT_EN
                state_q <= RAMP_UP;
`else
                state_q <= IDLE;
                pwm_q   <= '0;
`endif
              end else begin
                hold_q <= hold_q + 8'd1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign led        = led_q;
  assign busy       = (state_q != IDLE);
  assign duty       = duty_q;
  assign cycle_done = done_q;

endmodule

// File: doc/led_fade_sequencer.md
LED_FADE_SEQUENCER -- requirements
Module: led_fade_sequencer

Interface
- REQ-001: Parameter LENGTH, default 30, sets the PWM period in clocks and the maximum duty value; legal range 2..255.
- REQ-002: Parameter SPEED_DOWN, default 300, sets the clocks per duty step (one step tick); legal range 1..65535.
- REQ-003: Parameter HOLD, default 4, sets the dwell in step ticks at full and zero brightness; legal range 1..255.
- REQ-004: clk  input  1  sole clock; all state updates on the rising edge.
- REQ-005: rst  input  1  asynchronous, active-low reset.
- REQ-006: start  input  1  level; requests a fade sequence when idle.
- REQ-007: stop  input  1  level; aborts any sequence.
- REQ-008: led  output  1  registered PWM drive.
- REQ-009: busy  output  1  high in every state except IDLE.
- REQ-010: duty  output  8  current duty value, 0..LENGTH.
- REQ-011: cycle_done  output  1  one-clock pulse at the end of each full fade cycle.

Function
- REQ-012: The FSM SHALL have the states IDLE, RAMP_UP, HOLD_ON, RAMP_DOWN and HOLD_OFF.
- REQ-013: pwm_cnt SHALL count 0..LENGTH-1 and wrap, free-running in all states except IDLE, where it is held at 0.
- REQ-014: led SHALL be registered as (pwm_cnt < duty), one clock of latency; duty 0 gives constant 0 and duty LENGTH gives constant 1.
- REQ-015: The step timer SHALL count 0..SPEED_DOWN-1 and wrap, asserting a tick on its terminal value; it SHALL be cleared on every state entry.
- REQ-016: IDLE with start=1 and stop=0 SHALL move to RAMP_UP on the next edge, with duty=0 and all timers cleared.
- REQ-017: start SHALL be ignored while busy=1.
- REQ-018: In RAMP_UP, each tick SHALL increment duty; the tick that makes duty equal LENGTH SHALL also move the FSM to HOLD_ON.
- REQ-019: HOLD_ON SHALL last exactly HOLD ticks, then move to RAMP_DOWN.
- REQ-020: In RAMP_DOWN, each tick SHALL decrement duty; the tick that makes duty equal 0 SHALL also move the FSM to HOLD_OFF.
- REQ-021: HOLD_OFF SHALL last HOLD ticks.
- REQ-022: On the HOLD_OFF exit edge, cycle_done SHALL pulse high for one clock.
- REQ-023: duty SHALL never exceed LENGTH or wrap below 0; the arithmetic SHALL saturate.
- REQ-024: stop=1 in any state SHALL force IDLE on the next edge, with duty=0, led=0, busy=0 and no cycle_done pulse.
- REQ-025: If start and stop are both high in the same clock, stop SHALL win.
- REQ-026: One full cycle SHALL take 2*(LENGTH+HOLD)*SPEED_DOWN clocks from RAMP_UP entry to cycle_done.

Reset
- REQ-027: rst=0 SHALL immediately, and without waiting for a clock edge, force state=IDLE, duty=0, led=0, busy=0, cycle_done=0, and clear pwm_cnt and the step and hold timers.
- REQ-028: After rst deasserts, the block SHALL stay in IDLE until start is sampled high.
- REQ-029: Reset asserted mid-sequence SHALL abort the sequence with no cycle_done pulse.

Configuration
- REQ-030: With LED_FADE_REPEAT_EN defined, the HOLD_OFF exit SHALL go to RAMP_UP and the sequence SHALL loop until stop or reset, pulsing cycle_done once per cycle.
- REQ-031: Without LED_FADE_REPEAT_EN, the HOLD_OFF exit SHALL go to IDLE, so busy falls on the same edge that cycle_done rises.

Verification (LENGTH=4, SPEED_DOWN=2, HOLD=1)
- REQ-032: Reset release, start pulsed one clock -> busy rises next edge; duty steps 1,2,3,4 every 2 clocks; HOLD_ON 2 clocks; duty steps 3,2,1,0; cycle_done pulses 20 clocks after RAMP_UP entry.
- REQ-033: Hold duty=2 in RAMP_UP -> led pattern 1,1,0,0 repeating with period 4, lagging pwm_cnt by one clock.
- REQ-034: Assert stop during RAMP_DOWN at duty=3 -> next edge gives IDLE, duty=0, led=0, busy=0, and no cycle_done.
- REQ-035: Assert start and stop together while in IDLE -> FSM stays in IDLE and busy stays 0.
- REQ-036: Drive rst low mid HOLD_ON -> outputs clear asynchronously before the next edge; after release, idle until start.
- REQ-037: With LED_FADE_REPEAT_EN, 3 cycles run -> cycle_done pulses at 20, 40 and 60 clocks and busy stays 1; without the macro, busy=0 after 20 clocks.
